// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requestor-side and SDRAM-controller-side signals around the port arbiter.
// The arbiter takes the slave modport; requestors and the controller take the master modport.
interface sdram_port_arbiter_if #(
  parameter int NCH = 3,
  parameter int AW  = 25,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    we;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] din;
  logic [NCH-1:0]    excl;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout;

  modport slave (
    input  req, we, addr, din, excl, mem_dout,
    output gnt, ack, rdata, mem_cs, mem_we, mem_addr, mem_din
  );

  modport master (
    output req, we, addr, din, excl, mem_dout,
    input  gnt, ack, rdata, mem_cs, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Serialises NCH requestors onto the single SDRAM controller port, holding the winner's
// address/data/we for a fixed access window. Fixed-priority or round-robin arbitration.
module sdram_port_arbiter #(
  parameter int NCH           = 3,
  parameter int AW            = 25,
  parameter int DW            = 8,
  parameter int ACCESS_CYCLES = 4,
  parameter int RR_MODE       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  sdram_port_arbiter_if.slave   bus
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam int PW = $clog2(NCH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           mem_cs_q, mem_cs_d;
  logic           mem_we_q, mem_we_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [DW-1:0]  mem_din_q, mem_din_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [AW-1:0]  addr_arr [NCH];
  logic [DW-1:0]  din_arr  [NCH];
  logic [NCH-1:0] elig;
  logic [PW-1:0]  win;
  logic           win_vld;
  logic [PW-1:0]  cand;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.addr[gi*AW +: AW];
      assign din_arr[gi]  = bus.din[gi*DW +: DW];
    end
  endgenerate

  // A nonzero exclusive mask restricts arbitration to the masked channels only.
  assign elig = bus.req & ((bus.excl != '0) ? bus.excl : {NCH{1'b1}});

  // Loops run from the far end so the preferred candidate is assigned last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    if (RR_MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (elig[i]) begin
          win     = PW'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NCH; k >= 1; k--) begin
        cand = PW'((int'(rr_ptr_q) + k) % NCH);
        if (elig[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    mem_cs_d   = mem_cs_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d      = NCH'(1) << win;
          mem_cs_d   = 1'b1;
          mem_we_d   = bus.we[win];
          mem_addr_d = addr_arr[win];
          mem_din_d  = din_arr[win];
          cnt_d      = CW'(ACCESS_CYCLES - 1);
          if (RR_MODE != 0) rr_ptr_d = win;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          if (!mem_we_q) rdata_d = bus.mem_dout;
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          ack_d    = gnt_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d    = '0;
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rr_ptr_q   <= PW'(NCH - 1);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_cs   = mem_cs_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with identical stimulus and checks
// each against a transaction-level reference model of the arbitration rules.
module tb_sdram_port_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 25;
  localparam int DW  = 8;
  localparam int AC  = 4;
  localparam int AWT = NCH * AW;
  localparam int DWT = NCH * DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NCH-1:0] d_req, d_excl, d_we;
  logic [AWT-1:0] d_addr;
  logic [DWT-1:0] d_din;
  logic [DW-1:0]  d_dout;

  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) if_fix ();
  sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) if_rr ();

  assign if_fix.req = d_req;   assign if_rr.req = d_req;
  assign if_fix.excl = d_excl; assign if_rr.excl = d_excl;
  assign if_fix.we = d_we;     assign if_rr.we = d_we;
  assign if_fix.addr = d_addr; assign if_rr.addr = d_addr;
  assign if_fix.din = d_din;   assign if_rr.din = d_din;
  assign if_fix.mem_dout = d_dout; assign if_rr.mem_dout = d_dout;

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ACCESS_CYCLES(AC), .RR_MODE(0)) u_fix (
    .clk(clk), .reset(reset), .bus(if_fix.slave));
  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .ACCESS_CYCLES(AC), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .bus(if_rr.slave));

  logic [NCH-1:0] o_gnt [2], o_ack [2];
  logic           o_cs [2], o_we [2];
  logic [AW-1:0]  o_addr [2];
  logic [DW-1:0]  o_din [2], o_rdata [2];
  assign o_gnt[0] = if_fix.gnt;        assign o_gnt[1] = if_rr.gnt;
  assign o_ack[0] = if_fix.ack;        assign o_ack[1] = if_rr.ack;
  assign o_cs[0] = if_fix.mem_cs;      assign o_cs[1] = if_rr.mem_cs;
  assign o_we[0] = if_fix.mem_we;      assign o_we[1] = if_rr.mem_we;
  assign o_addr[0] = if_fix.mem_addr;  assign o_addr[1] = if_rr.mem_addr;
  assign o_din[0] = if_fix.mem_din;    assign o_din[1] = if_rr.mem_din;
  assign o_rdata[0] = if_fix.rdata;    assign o_rdata[1] = if_rr.rdata;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference model state: round-robin last winner and each DUT's last read data.
  int             rr_last;
  logic [DW-1:0]  rdata_m [2];

  function automatic int pick(input logic [NCH-1:0] r, input logic [NCH-1:0] ex,
                              input int mode, input int last);
    logic [NCH-1:0] e;
    e = r & ((ex != '0) ? ex : {NCH{1'b1}});
    if (e == '0) return -1;
    if (mode == 0) begin
      for (int i = 0; i < NCH; i++) if (e[i]) return i;
    end else begin
      for (int k = 1; k <= NCH; k++) if (e[(last + k) % NCH]) return (last + k) % NCH;
    end
    return -1;
  endfunction

  task automatic run_txn(input logic [NCH-1:0] r, input logic [NCH-1:0] ex,
                         input logic [NCH-1:0] wv, input logic [AWT-1:0] a,
                         input logic [DWT-1:0] dn, input logic [DW-1:0] dout, input bit hold,
                         output logic [NCH-1:0] g0, output logic [NCH-1:0] g1, output int ack_at);
    int w [2];
    logic [NCH-1:0] eg [2];
    @(negedge clk);
    d_req = r; d_excl = ex; d_we = wv; d_addr = a; d_din = dn; d_dout = dout;
    w[0] = pick(r, ex, 0, 0);
    w[1] = pick(r, ex, 1, rr_last);
    @(posedge clk); #1;
    g0 = o_gnt[0]; g1 = o_gnt[1]; ack_at = -1;
    if (w[0] < 0) begin
      for (int d = 0; d < 2; d++) begin
        chk("idle_gnt", 32'(o_gnt[d]), 32'd0);
        chk("idle_cs", 32'(o_cs[d]), 32'd0);
      end
      $display("txn req=%b excl=%b -> no eligible requestor", r, ex);
      return;
    end
    rr_last = w[1];
    for (int d = 0; d < 2; d++) begin
      eg[d] = NCH'(1) << w[d];
      chk("grant_gnt", 32'(o_gnt[d]), 32'(eg[d]));
      chk("grant_cs", 32'(o_cs[d]), 32'd1);
      chk("grant_we", 32'(o_we[d]), 32'(wv[w[d]]));
      chk("grant_addr", 32'(o_addr[d]), 32'(a[w[d]*AW +: AW]));
      chk("grant_din", 32'(o_din[d]), 32'(dn[w[d]*DW +: DW]));
    end
    for (int k = 1; k < AC; k++) begin
      @(negedge clk);
      d_req = NCH'($urandom); d_excl = NCH'($urandom); d_we = NCH'($urandom);
      d_addr = AWT'({$urandom, $urandom, $urandom}); d_din = DWT'({$urandom});
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("hold_cs", 32'(o_cs[d]), 32'd1);
        chk("hold_addr", 32'(o_addr[d]), 32'(a[w[d]*AW +: AW]));
        chk("hold_ack", 32'(o_ack[d]), 32'd0);
      end
    end
    @(posedge clk); #1;
    ack_at = cyc;
    for (int d = 0; d < 2; d++) begin
      if (!wv[w[d]]) rdata_m[d] = dout;
      chk("done_ack", 32'(o_ack[d]), 32'(eg[d]));
      chk("done_gnt", 32'(o_gnt[d]), 32'(eg[d]));
      chk("done_cs", 32'(o_cs[d]), 32'd0);
      chk("done_we", 32'(o_we[d]), 32'd0);
      chk("done_rdata", 32'(o_rdata[d]), 32'(rdata_m[d]));
    end
    @(negedge clk);
    d_req = hold ? r : '0; d_excl = ex;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("idle_ack", 32'(o_ack[d]), 32'd0);
      chk("idle_gnt_clr", 32'(o_gnt[d]), 32'd0);
    end
    $display("txn req=%b excl=%b we=%b -> fixed ch%0d rr ch%0d", r, ex, wv, w[0], w[1]);
  endtask

  initial begin
    logic [NCH-1:0] g0, g1;
    logic [NCH-1:0] rr_exp [4];
    logic [AWT-1:0] a;
    logic [DWT-1:0] dn;
    int t0, t1;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    d_req = '0; d_excl = '0; d_we = '0; d_addr = '0; d_din = '0; d_dout = '0;
    reset = 1'b1;
    rr_last = NCH - 1;
    rdata_m[0] = '0; rdata_m[1] = '0;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt", 32'(o_gnt[d]), 32'd0);
      chk("rst_ack", 32'(o_ack[d]), 32'd0);
      chk("rst_cs", 32'(o_cs[d]), 32'd0);
      chk("rst_we", 32'(o_we[d]), 32'd0);
      chk("rst_addr", 32'(o_addr[d]), 32'd0);
      chk("rst_rdata", 32'(o_rdata[d]), 32'd0);
    end
    @(negedge clk); reset = 1'b0;

    // All three requesting: fixed priority keeps serving ch0, round-robin rotates.
    for (int i = 0; i < 4; i++) begin
      run_txn(3'b111, 3'b000, 3'b000, AWT'(i), DWT'(0), 8'(i + 1), 1'b0, g0, g1, t0);
      chk("prio_fixed", 32'(g0), 32'b001);
      chk("prio_rr", 32'(g1), 32'(rr_exp[i]));
    end

    a = '0; a[1*AW +: AW] = 25'h0042;
    run_txn(3'b010, 3'b000, 3'b000, a, DWT'(0), 8'hA5, 1'b0, g0, g1, t0);
    chk("read_rdata_fix", 32'(o_rdata[0]), 32'hA5);
    chk("read_rdata_rr", 32'(o_rdata[1]), 32'hA5);

    a = '0; a[2*AW +: AW] = 25'h1234; dn = '0; dn[2*DW +: DW] = 8'h5A;
    run_txn(3'b100, 3'b000, 3'b100, a, dn, 8'h33, 1'b0, g0, g1, t0);
    chk("write_gnt", 32'(g0), 32'b100);
    chk("write_rdata_kept", 32'(o_rdata[0]), 32'hA5);

    for (int i = 0; i < 3; i++) begin
      run_txn(3'b011, 3'b010, 3'b000, AWT'($urandom), DWT'(0), 8'($urandom), 1'b0, g0, g1, t0);
      chk("excl_fixed", 32'(g0), 32'b010);
      chk("excl_rr", 32'(g1), 32'b010);
    end
    run_txn(3'b011, 3'b000, 3'b000, AWT'($urandom), DWT'(0), 8'($urandom), 1'b0, g0, g1, t0);
    chk("excl_clr_fixed", 32'(g0), 32'b001);
    chk("excl_clr_rr", 32'(g1), 32'b001);

    // Reset during the second access cycle of a write.
    @(negedge clk);
    d_req = 3'b001; d_we = 3'b001; d_excl = '0;
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(o_we[0]), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1; d_req = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("midrst_cs", 32'(o_cs[d]), 32'd0);
      chk("midrst_we", 32'(o_we[d]), 32'd0);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) chk("midrst_ack", 32'(o_ack[d]), 32'd0);
    @(negedge clk); reset = 1'b0;
    rr_last = NCH - 1; rdata_m[0] = '0; rdata_m[1] = '0;
    run_txn(3'b011, 3'b000, 3'b000, AWT'($urandom), DWT'(0), 8'h7E, 1'b0, g0, g1, t0);
    chk("post_rst_rr", 32'(g1), 32'b001);

    run_txn(3'b001, 3'b000, 3'b000, AWT'($urandom), DWT'(0), 8'h11, 1'b1, g0, g1, t0);
    run_txn(3'b001, 3'b000, 3'b000, AWT'($urandom), DWT'(0), 8'h22, 1'b0, g0, g1, t1);
    chk("b2b_ack_period", 32'(t1 - t0), 32'(AC + 2));

    for (int i = 0; i < 150; i++) begin
      run_txn(NCH'($urandom), ($urandom_range(0, 3) == 0) ? NCH'($urandom) : NCH'(0),
              NCH'($urandom), AWT'({$urandom, $urandom, $urandom}), DWT'($urandom),
              8'($urandom), bit'($urandom_range(0, 1)), g0, g1, t0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
